// File: rtl/id_operand_scoreboard_if.sv
// rtl/id_operand_scoreboard_if.sv - decode-stage operand scoreboard bus
interface id_operand_scoreboard_if #(
   parameter int REG_W = 5,
   parameter int FWD_W = 2,
   parameter int OCC_W = 2,
   parameter int CNT_W = 16
);
   logic             id_valid;
   logic [REG_W-1:0] id_rf1;
   logic             id_rf1_used;
   logic [REG_W-1:0] id_rf2;
   logic             id_rf2_used;
   logic [REG_W-1:0] id_rd;
   logic             id_rd_we;
   logic             id_is_load;
   logic             flush;
   logic             stall;
   logic [FWD_W-1:0] fwd1_sel;
   logic [FWD_W-1:0] fwd2_sel;
   logic [OCC_W-1:0] busy_count;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output id_valid, id_rf1, id_rf1_used, id_rf2, id_rf2_used,
             id_rd, id_rd_we, id_is_load, flush,
      input  stall, fwd1_sel, fwd2_sel, busy_count, stall_count
   );

   modport slave (
      input  id_valid, id_rf1, id_rf1_used, id_rf2, id_rf2_used,
             id_rd, id_rd_we, id_is_load, flush,
      output stall, fwd1_sel, fwd2_sel, busy_count, stall_count
   );
endinterface

// File: rtl/id_operand_scoreboard.sv
// rtl/id_operand_scoreboard.sv - ID hazard unit: forwarding select, load-use stall, counters
module id_operand_scoreboard #(
   parameter int REG_W      = 5,
   parameter int ZERO_REG   = 31,
   parameter int PIPE_DEPTH = 3,
   parameter int LOAD_READY = 1,
   parameter int CNT_W      = 16,
   localparam int FWD_W     = $clog2(PIPE_DEPTH + 1),
   localparam int OCC_W     = $clog2(PIPE_DEPTH + 1)
) (
   input logic                    clk,
   input logic                    rst,
   id_operand_scoreboard_if.slave bus
);
   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
      logic             is_load;
   } entry_t;

   localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);

   entry_t           tbl [PIPE_DEPTH];
   logic [CNT_W-1:0] stall_cnt;
   logic [FWD_W-1:0] fwd1, fwd2;
   logic             early_load1, early_load2;
   logic [OCC_W-1:0] occ;
   logic             stall_c;

   // Walk oldest to youngest so the last hit recorded is the youngest producer.
   always_comb begin
      fwd1        = '0;
      fwd2        = '0;
      early_load1 = 1'b0;
      early_load2 = 1'b0;
      for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
         if (bus.id_rf1_used && tbl[i].valid && tbl[i].rd == bus.id_rf1 && bus.id_rf1 != ZERO_IDX) begin
            fwd1        = FWD_W'(i + 1);
            early_load1 = tbl[i].is_load && (i < LOAD_READY);
         end
         if (bus.id_rf2_used && tbl[i].valid && tbl[i].rd == bus.id_rf2 && bus.id_rf2 != ZERO_IDX) begin
            fwd2        = FWD_W'(i + 1);
            early_load2 = tbl[i].is_load && (i < LOAD_READY);
         end
      end
   end

   always_comb begin
      occ = '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
         occ = occ + OCC_W'(tbl[i].valid);
      end
   end

   assign stall_c = bus.id_valid && (early_load1 || early_load2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            tbl[i] <= '0;
         end
         stall_cnt <= '0;
      end else begin
         for (int i = 1; i < PIPE_DEPTH; i++) begin
            tbl[i] <= bus.flush ? '0 : tbl[i-1];
         end
         // A stalled instruction re-presents next cycle, so it enters as a bubble now.
         if (bus.flush || stall_c || !bus.id_valid) begin
            tbl[0] <= '0;
         end else begin
            tbl[0].valid   <= bus.id_rd_we && (bus.id_rd != ZERO_IDX);
            tbl[0].rd      <= bus.id_rd;
            tbl[0].is_load <= bus.id_is_load;
         end
         if (stall_c && !bus.flush && stall_cnt != {CNT_W{1'b1}}) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.stall       = stall_c;
   assign bus.fwd1_sel    = fwd1;
   assign bus.fwd2_sel    = fwd2;
   assign bus.busy_count  = occ;
   assign bus.stall_count = stall_cnt;
endmodule

// File: tb/tb_id_operand_scoreboard.sv
// tb/tb_id_operand_scoreboard.sv - directed self-checking bench for id_operand_scoreboard
module tb_id_operand_scoreboard;
   localparam int REG_W = 5;
   localparam int CNT_W = 3;
   localparam int FWD_W = 2;
   localparam int OCC_W = 2;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   id_operand_scoreboard_if #(.REG_W(REG_W), .FWD_W(FWD_W), .OCC_W(OCC_W), .CNT_W(CNT_W)) bus ();

   id_operand_scoreboard #(
      .REG_W(REG_W), .ZERO_REG(31), .PIPE_DEPTH(3), .LOAD_READY(1), .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2,
                        input logic [4:0] rd, input logic we, input logic ld, input logic fl);
      bus.id_valid    = v;
      bus.id_rf1      = r1;
      bus.id_rf1_used = u1;
      bus.id_rf2      = r2;
      bus.id_rf2_used = u2;
      bus.id_rd       = rd;
      bus.id_rd_we    = we;
      bus.id_is_load  = ld;
      bus.flush       = fl;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // Load X5, then a reader of X5: exactly one stalled edge.
   task automatic stall_once();
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
      tick();
      drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
   endtask

   initial begin
      idle();
      #2;
      check("reset_busy", bus.busy_count, 0);
      check("reset_stall", bus.stall, 0);
      check("reset_fwd1", bus.fwd1_sel, 0);
      check("reset_stall_count", bus.stall_count, 0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // 1: three writers, then asynchronous reset without a clock edge
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0); tick();
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0); tick();
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0); tick();
      drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      check("t1_busy_full", bus.busy_count, 3);
      check("t1_fwd1_before_rst", bus.fwd1_sel, 3);
      #1 rst = 1'b1;
      #1;
      check("t1_busy_after_rst", bus.busy_count, 0);
      check("t1_stall_after_rst", bus.stall, 0);
      check("t1_fwd1_after_rst", bus.fwd1_sel, 0);
      rst = 1'b0;
      idle();
      tick();

      // 2: ALU forwarding from entry 0 then entry 1
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0); tick();
      drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      check("t2_fwd1_e0", bus.fwd1_sel, 1);
      check("t2_stall", bus.stall, 0);
      tick();
      check("t2_fwd1_e1", bus.fwd1_sel, 2);
      tick();

      // 3: load-use stall lasts one cycle then forwards from entry 1
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0); tick();
      drive(1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      check("t3_stall_on", bus.stall, 1);
      check("t3_count_before", bus.stall_count, 0);
      tick();
      check("t3_stall_off", bus.stall, 0);
      check("t3_fwd2", bus.fwd2_sel, 2);
      check("t3_count_after", bus.stall_count, 1);
      tick();

      // 4: youngest producer wins; an older load does not stall
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0); tick();
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0); tick();
      drive(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      check("t4_fwd1_youngest", bus.fwd1_sel, 1);
      check("t4_fwd2_youngest", bus.fwd2_sel, 1);
      check("t4_no_stall", bus.stall, 0);
      tick();

      // 5: XZR is never tracked or matched
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1); tick();
      check("t5_busy_after_flush", bus.busy_count, 0);
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0); tick();
      drive(1'b1, 5'd31, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      check("t5_busy_xzr", bus.busy_count, 0);
      check("t5_fwd1_xzr", bus.fwd1_sel, 0);
      tick();

      // 6: flush beats id_valid and stall
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0); tick();
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0); tick();
      drive(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      check("t6_busy_two", bus.busy_count, 2);
      check("t6_fwd1_pre", bus.fwd1_sel, 1);
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1); tick();
      drive(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      check("t6_busy_flushed", bus.busy_count, 0);
      check("t6_fwd1_flushed", bus.fwd1_sel, 0);
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0); tick();
      drive(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      check("t6_stall_with_flush", bus.stall, 1);
      tick();
      check("t6_count_flush_stall", bus.stall_count, 1);
      check("t6_busy_flush_stall", bus.busy_count, 0);

      // stall counter saturation
      for (int k = 0; k < 5; k++) stall_once();
      check("sat_max_minus1", bus.stall_count, CMAX - 1);
      stall_once();
      check("sat_reach_max", bus.stall_count, CMAX);
      stall_once();
      stall_once();
      check("sat_hold_max", bus.stall_count, CMAX);

      idle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
